// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one cache-bus port among NUM_REQ requesters, one burst at a time.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise lowest valid index wins.

package cbus_pkg;

    typedef enum logic [2:0] {
        MLEN1  = 3'd0,
        MLEN2  = 3'd1,
        MLEN4  = 3'd2,
        MLEN8  = 3'd3,
        MLEN16 = 3'd4
    } cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        cbus_len_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_REQ],
    output cbus_resp_t       iresps [NUM_REQ],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_sel;
    logic [IDX_W-1:0]   w_sel_next;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_last_grant_next;
    logic [IDX_W-1:0]   w_winner;
    logic [NUM_REQ-1:0] w_valid;
    logic               w_any_valid;

    always_comb begin
        w_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_valid[i] = ireqs[i].valid;
        end
    end

    assign w_any_valid = |w_valid;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    // Search starts just after the previous winner and wraps around.
    always_comb begin : rr_pick
        logic        found;
        int unsigned idx;
        found    = 1'b0;
        idx      = 0;
        w_winner = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(r_last_grant) + k) % 32'(NUM_REQ);
            if (!found && w_valid[IDX_W'(idx)]) begin
                w_winner = IDX_W'(idx);
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin : fixed_pick
        logic found;
        found    = 1'b0;
        w_winner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && w_valid[IDX_W'(i)]) begin
                w_winner = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state      <= w_state_next;
            r_sel        <= w_sel_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_sel_next        = r_sel;
        w_last_grant_next = r_last_grant;
        oreq              = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            iresps[j] = '0;
        end

        unique case (r_state)
            S_IDLE: begin
                if (w_any_valid) begin
                    w_state_next      = S_BUSY;
                    w_sel_next        = w_winner;
                    w_last_grant_next = w_winner;
                end
            end
            S_BUSY: begin
                // Grant is held until the memory beat carrying last, regardless of valid.
                oreq          = ireqs[r_sel];
                iresps[r_sel] = oresp;
                if (oresp.ready && oresp.last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign busy      = (r_state == S_BUSY);
    assign grant_idx = r_sel;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: directed scenarios plus randomized traffic against a burst-level model.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int N  = 3;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset;
    cbus_req_t     ireqs  [N];
    cbus_resp_t    iresps [N];
    cbus_req_t     oreq;
    cbus_resp_t    oresp;
    logic          busy;
    logic [IW-1:0] grant_idx;

    cbus_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Requester-side state and burst-level model of the arbiter/memory pair.
    cbus_req_t req_q [N];
    int        rearm [N];
    bit        just_done [N];
    int        owner = -1;
    int        last_g = N - 1;
    int        shown = 0;
    int        beat = 0;
    int        ready_mode = 0;
    bit        tog = 1'b0;

    // What was actually observed on the DUT.
    int obs_start[$];
    int obs_gidx[$];
    int obs_addr[$];
    int obs_end[$];
    int obs_end_req[$];
    int busy_obs = 0;
    bit prev_v = 1'b0;

    int exp_b [3];
    int t0;
    int issued;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qg(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic cbus_req_t mk_req(input logic [31:0] addr, input cbus_len_t len,
                                         input logic wr, input logic [31:0] data);
        cbus_req_t q;
        q          = '0;
        q.valid    = 1'b1;
        q.is_write = wr;
        q.size     = 3'd2;
        q.addr     = addr;
        q.strobe   = wr ? 4'hf : 4'h0;
        q.data     = data;
        q.len      = len;
        return q;
    endfunction

    function automatic int nbeats(input cbus_len_t l);
        return 1 << int'(l);
    endfunction

    function automatic int pick();
        int w = -1;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (w < 0 && req_q[(last_g + k) % N].valid) w = (last_g + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (w < 0 && req_q[i].valid) w = i;
        end
`endif
        return w;
    endfunction

    function automatic cbus_req_t rand_req();
        return mk_req($urandom & 32'hffff_fffc, cbus_len_t'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom);
    endfunction

    task automatic clear_obs();
        obs_start.delete();
        obs_gidx.delete();
        obs_addr.delete();
        obs_end.delete();
        obs_end_req.delete();
        busy_obs = 0;
    endtask

    task automatic reset_model();
        owner  = -1;
        last_g = N - 1;
        shown  = 0;
        beat   = 0;
        prev_v = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_q[i]     = '0;
            rearm[i]     = 0;
            just_done[i] = 1'b0;
        end
    endtask

    // One clock cycle: drive, check against the model, log observations, advance.
    task automatic step();
        bit r;
        int nxt;
        bit fin;
        bit adv;
        r = 1'b0;
        for (int i = 0; i < N; i++) ireqs[i] = req_q[i];
        oresp = '0;
        if (owner >= 0) begin
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = tog;
                default: r = 1'($urandom_range(0, 1));
            endcase
            oresp.ready = r;
            oresp.last  = r && (beat == nbeats(req_q[owner].len) - 1);
            oresp.data  = $urandom;
        end else begin
            oresp.ready = 1'($urandom_range(0, 1));
            oresp.last  = 1'($urandom_range(0, 1));
            oresp.data  = $urandom;
        end
        #1;
        if (owner < 0) begin
            chk("idle_oreq", 128'(oreq), 128'(0));
            chk("idle_busy", 128'(busy), 128'(0));
            chk("idle_gidx", 128'(grant_idx), 128'(shown));
            for (int j = 0; j < N; j++) chk("idle_resp", 128'(iresps[j]), 128'(0));
        end else begin
            chk("fwd_oreq", 128'(oreq), 128'(req_q[owner]));
            chk("busy_busy", 128'(busy), 128'(1));
            chk("busy_gidx", 128'(grant_idx), 128'(owner));
            for (int j = 0; j < N; j++) begin
                if (j == owner) chk("fwd_resp", 128'(iresps[j]), 128'(oresp));
                else            chk("other_resp", 128'(iresps[j]), 128'(0));
            end
        end
        if (oreq.valid && !prev_v) begin
            obs_start.push_back(cyc);
            obs_gidx.push_back(int'(grant_idx));
            obs_addr.push_back(int'(oreq.addr));
        end
        prev_v = oreq.valid;
        for (int j = 0; j < N; j++) begin
            if (iresps[j].ready && iresps[j].last) begin
                obs_end.push_back(cyc);
                obs_end_req.push_back(j);
            end
        end
        if (busy) busy_obs++;

        nxt = owner;
        fin = 1'b0;
        adv = 1'b0;
        if (owner < 0) nxt = pick();
        else if (oresp.ready) begin
            if (oresp.last) fin = 1'b1;
            else            adv = 1'b1;
        end

        @(posedge clk);
        cyc++;
        #1;
        if (owner < 0 && nxt >= 0) begin
            owner  = nxt;
            last_g = nxt;
            shown  = nxt;
            beat   = 0;
            tog    = 1'b0;
        end else if (owner >= 0) begin
            tog = ~tog;
            if (fin) begin
                if (rearm[owner] > 0) begin
                    rearm[owner]--;
                    req_q[owner] = mk_req($urandom & 32'hffff_fffc, MLEN4, 1'b0, 32'h0);
                end else begin
                    req_q[owner]     = '0;
                    just_done[owner] = 1'b1;
                end
                owner = -1;
            end else if (adv) begin
                beat++;
                if (req_q[owner].is_write) req_q[owner].data = req_q[owner].data + 32'd1;
            end
        end
    endtask

    task automatic run_until(input int n, input int budget);
        while (obs_end.size() < n && budget > 0) begin
            step();
            budget--;
        end
        chk("burst_timeout", 128'(obs_end.size()), 128'(n));
    endtask

    task automatic wait_start(input int budget);
        while (obs_start.size() == 0 && budget > 0) begin
            step();
            budget--;
        end
        chk("start_timeout", 128'(obs_start.size()), 128'(1));
    endtask

    task automatic drain(input int budget);
        bit pend;
        pend = 1'b1;
        while (pend && budget > 0) begin
            step();
            budget--;
            pend = (owner >= 0);
            for (int i = 0; i < N; i++) if (req_q[i].valid) pend = 1'b1;
        end
        step();
        chk("drain_busy", 128'(busy), 128'(0));
    endtask

    initial begin
`ifdef CBUS_ARB_ROUND_ROBIN_EN
        exp_b = '{0, 1, 0};
`else
        exp_b = '{0, 0, 0};
`endif
        reset = 1'b1;
        oresp = '0;
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        reset_model();
        #1;
        chk("rst_oreq", 128'(oreq), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_gidx", 128'(grant_idx), 128'(0));
        chk("rst_resp0", 128'(iresps[0]), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Lone 16-beat read from requester 1, memory always ready.
        clear_obs();
        ready_mode = 0;
        req_q[1] = mk_req(32'h1000_0040, MLEN16, 1'b0, 32'h0);
        t0 = cyc;
        run_until(1, 40);
        step();
        step();
        chk("lone_lat", 128'(qg(obs_start, 0)), 128'(t0 + 1));
        chk("lone_addr", 128'(qg(obs_addr, 0)), 128'(32'h1000_0040));
        chk("lone_gidx", 128'(qg(obs_gidx, 0)), 128'(1));
        chk("lone_end", 128'(qg(obs_end, 0)), 128'(t0 + 16));
        chk("lone_endreq", 128'(qg(obs_end_req, 0)), 128'(1));
        chk("lone_busycnt", 128'(busy_obs), 128'(16));

        // Simultaneous requests 0 and 1; requester 0 re-requests back to back twice.
        clear_obs();
        req_q[0] = mk_req(32'h0000_0100, MLEN4, 1'b0, 32'h0);
        req_q[1] = mk_req(32'h0000_0200, MLEN4, 1'b0, 32'h0);
        rearm[0] = 2;
        t0 = cyc;
        run_until(3, 60);
        chk("sim_lat", 128'(qg(obs_start, 0)), 128'(t0 + 1));
        for (int i = 0; i < 3; i++) chk("sim_order", 128'(qg(obs_gidx, i)), 128'(exp_b[i]));
        chk("sim_gap1", 128'(qg(obs_start, 1) - qg(obs_end, 0)), 128'(2));
        chk("sim_gap2", 128'(qg(obs_start, 2) - qg(obs_end, 1)), 128'(2));
        drain(100);

        // Write burst with alternating memory ready, first BUSY cycle not ready.
        clear_obs();
        ready_mode = 1;
        req_q[0] = mk_req(32'h0000_3000, MLEN16, 1'b1, 32'h0);
        t0 = cyc;
        run_until(1, 80);
        step();
        chk("wr_lat", 128'(qg(obs_start, 0)), 128'(t0 + 1));
        chk("wr_busycnt", 128'(busy_obs), 128'(32));
        chk("wr_span", 128'(qg(obs_end, 0) - qg(obs_start, 0)), 128'(31));

        // Late arrival: requester 1 appears during requester 0's 8th beat.
        clear_obs();
        ready_mode = 0;
        req_q[0] = mk_req(32'h0000_4000, MLEN16, 1'b0, 32'h0);
        wait_start(10);
        repeat (6) step();
        req_q[1] = mk_req(32'h0000_5000, MLEN2, 1'b0, 32'h0);
        run_until(2, 60);
        chk("late_first", 128'(qg(obs_end_req, 0)), 128'(0));
        chk("late_span", 128'(qg(obs_end, 0) - qg(obs_start, 0)), 128'(15));
        chk("late_gidx", 128'(qg(obs_gidx, 1)), 128'(1));
        chk("late_gap", 128'(qg(obs_start, 1) - qg(obs_end, 0)), 128'(2));
        drain(40);

        // Mid-burst reset during beat 5 of requester 2's burst.
        clear_obs();
        req_q[2] = mk_req(32'h0000_6000, MLEN16, 1'b0, 32'h0);
        wait_start(10);
        repeat (3) step();
        for (int i = 0; i < N; i++) ireqs[i] = req_q[i];
        oresp       = '0;
        oresp.ready = 1'b1;
        reset       = 1'b1;
        #1;
        chk("mrst_valid", 128'(oreq.valid), 128'(0));
        chk("mrst_busy", 128'(busy), 128'(0));
        chk("mrst_gidx", 128'(grant_idx), 128'(0));
        chk("mrst_resp", 128'(iresps[2]), 128'(0));
        reset_model();
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b0;
        clear_obs();
        req_q[1] = mk_req(32'h0000_2000, MLEN1, 1'b0, 32'h0);
        t0 = cyc;
        run_until(1, 10);
        chk("post_lat", 128'(qg(obs_start, 0)), 128'(t0 + 1));
        chk("post_addr", 128'(qg(obs_addr, 0)), 128'(32'h0000_2000));
        chk("post_gidx", 128'(qg(obs_gidx, 0)), 128'(1));
        chk("post_end", 128'(qg(obs_end, 0)), 128'(t0 + 1));
        drain(20);

        // Randomized traffic: every issued request must complete exactly once.
        clear_obs();
        ready_mode = 2;
        issued = 0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                if (just_done[i]) just_done[i] = 1'b0;
                else if (!req_q[i].valid && $urandom_range(0, 3) == 0) begin
                    req_q[i] = rand_req();
                    issued++;
                end
            end
            step();
        end
        drain(400);
        chk("rand_complete", 128'(obs_end.size()), 128'(issued));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
